mips_regfile_sb: RTL and testbench

Parametrised register file with an integrated per-register scoreboard for the pipelined MIPS core. It replaces the fixed two-read/one-write file in the decode stage. It supplies operands to decode, takes the stage-5 writeback, and tracks in-flight writers per destination register. From that tracking it raises a decode `stall` on RAW hazards, so the pipeline no longer depends on forwarding alone.

---
 rtl/mips_pkg.sv | 12 +
 rtl/sb_counter.sv | 42 ++++
 rtl/mips_regfile_sb.sv | 111 +++++++++++
 tb/tb_mips_regfile_sb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and address type for the MIPS core register file.
package mips_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_NREGS  = 32;
   localparam int unsigned DEF_ADDR_W = $clog2(DEF_NREGS);

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/sb_counter.sv
// Saturating in-flight writer counter for one register: one increment, two decrements.
module sb_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec_w,
   input  logic             dec_k,
   output logic [CNT_W-1:0] cnt
);

   localparam int unsigned SUM_W = CNT_W + 2;

   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_nxt;

   // Net change in two's complement; sign bit flags underflow, bit CNT_W flags overflow.
   always_comb begin
      sum     = SUM_W'(cnt) + SUM_W'(inc) - SUM_W'(dec_w) - SUM_W'(dec_k);
      cnt_nxt = sum[CNT_W-1:0];
      if (sum[SUM_W-1]) begin
         cnt_nxt = '0;
      end else if (sum[CNT_W]) begin
         cnt_nxt = {CNT_W{1'b1}};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

`ifndef SYNTHESIS
   underflow_chk : assert property (@(posedge clk) disable iff (!reset) !sum[SUM_W-1])
      else $error("sb_counter: decrement of an idle register");
`endif

endmodule

// File: rtl/mips_regfile_sb.sv
// Register file with per-register writer scoreboard and RAW stall generation.
// Optional write-to-read bypass and early hazard release: define REGFILE_BYPASS_EN.
module mips_regfile_sb
   import mips_pkg::*;
#(
   parameter  int unsigned DATA_W = DEF_DATA_W,
   parameter  int unsigned NREGS  = DEF_NREGS,
   parameter  int unsigned NRD    = 2,
   parameter  int unsigned CNT_W  = 2,
   localparam int unsigned ADDR_W = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  issue_valid,
   input  logic                  issue_wr,
   input  logic [ADDR_W-1:0]     issue_dest,
   input  logic                  kill_valid,
   input  logic [ADDR_W-1:0]     kill_dest,
   output logic                  stall,
   output logic [NREGS-1:0]      busy
);

   localparam int unsigned HZ_W = CNT_W + 2;

   logic [DATA_W-1:0] regs [1:NREGS-1];
   logic [CNT_W-1:0]  cnt  [1:NREGS-1];
   logic [NREGS-1:1]  inc, dec_w, dec_k, hazard;
   logic              accept, raw, full;

   assign accept = issue_valid & ~stall & issue_wr;

   // Register 0 has no storage; writes to it fall through the decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 1; r < NREGS; r++) regs[r] <= '0;
      end else if (wr_en) begin
         for (int r = 1; r < NREGS; r++) begin
            if (wr_addr == ADDR_W'(r)) regs[r] <= wr_data;
         end
      end
   end

   // Per-register event decode and hazard qualification.
   always_comb begin
      inc    = '0;
      dec_w  = '0;
      dec_k  = '0;
      hazard = '0;
      busy   = '0;
      for (int r = 1; r < NREGS; r++) begin
         inc[r]   = accept && (issue_dest == ADDR_W'(r));
         dec_w[r] = wr_en && (wr_addr == ADDR_W'(r));
         dec_k[r] = kill_valid && (kill_dest == ADDR_W'(r));
         busy[r]  = (cnt[r] != '0);
`ifdef REGFILE_BYPASS_EN
         hazard[r] = (HZ_W'(cnt[r]) - HZ_W'(dec_w[r]) - HZ_W'(dec_k[r])) != '0;
`else
         hazard[r] = (HZ_W'(cnt[r]) != '0);
`endif
      end
   end

   for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (inc[r]),
         .dec_w (dec_w[r]),
         .dec_k (dec_k[r]),
         .cnt   (cnt[r])
      );
   end

   // Read muxes; register 0 and out-of-range addresses read as zero.
   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NRD; p++) begin
         for (int r = 1; r < NREGS; r++) begin
            if (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) rd_data[p*DATA_W +: DATA_W] = regs[r];
         end
`ifdef REGFILE_BYPASS_EN
         if (wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W]) &&
             (wr_addr != ADDR_W'(ZERO_REG))) begin
            rd_data[p*DATA_W +: DATA_W] = wr_data;
         end
`endif
      end
   end

   // Stall on a RAW hazard for any needed operand, or on a full destination counter.
   always_comb begin
      raw  = 1'b0;
      full = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         for (int r = 1; r < NREGS; r++) begin
            if (rd_en[p] && (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) && hazard[r]) raw = 1'b1;
         end
      end
      for (int r = 1; r < NREGS; r++) begin
         if (issue_wr && (issue_dest == ADDR_W'(r)) && (&cnt[r])) full = 1'b1;
      end
      stall = issue_valid & (raw | full);
   end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Bench for mips_regfile_sb: directed vector table, randomized run against a scoreboard model, async reset case.
module tb_mips_regfile_sb;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NP = 2;
   localparam int unsigned CW = 2;
   localparam int          CMAX = 3;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk, reset;
   logic [NP-1:0]     rd_en;
   logic [NP*AW-1:0]  rd_addr;
   logic [NP*DW-1:0]  rd_data;
   logic              wr_en, issue_valid, issue_wr, kill_valid, stall;
   logic [AW-1:0]     wr_addr, issue_dest, kill_dest;
   logic [DW-1:0]     wr_data;
   logic [NR-1:0]     busy;

   mips_regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NP), .CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .issue_valid (issue_valid),
      .issue_wr    (issue_wr),
      .issue_dest  (issue_dest),
      .kill_valid  (kill_valid),
      .kill_dest   (kill_dest),
      .stall       (stall),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv, iw;
      logic [4:0]  dest;
      logic [1:0]  re;
      logic [4:0]  a0, a1;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        kv;
      logic [4:0]  kd;
      logic        xs;
      logic [31:0] xd0, xd1, xbusy;
   } vec_t;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   int          mcnt [NR];
   logic [31:0] mreg [NR];
   vec_t        vt [18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic vec_t mk(input logic iv, input logic iw, input int dest, input logic [1:0] re,
                               input int a0, input int a1, input logic we, input int wa,
                               input logic [31:0] wd, input logic kv, input int kd,
                               input logic xs, input logic [31:0] xd0, input logic [31:0] xd1,
                               input logic [31:0] xbusy);
      vec_t v;
      v.iv = iv; v.iw = iw; v.dest = 5'(dest); v.re = re; v.a0 = 5'(a0); v.a1 = 5'(a1);
      v.we = we; v.wa = 5'(wa); v.wd = wd; v.kv = kv; v.kd = 5'(kd);
      v.xs = xs; v.xd0 = xd0; v.xd1 = xd1; v.xbusy = xbusy;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      issue_valid = v.iv; issue_wr = v.iw; issue_dest = v.dest;
      rd_en = v.re; rd_addr = {v.a1, v.a0};
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      kill_valid = v.kv; kill_dest = v.kd;
   endtask

   task automatic idle();
      vec_t v;
      v = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      drive(v);
   endtask

   // Reference model: counts of outstanding writers and architectural values.
   function automatic bit m_haz(input int r, input bit we, input int wa, input bit kv, input int kd);
      int n;
      n = mcnt[r];
      if (BYP) n = n - int'(we && wa == r) - int'(kv && kd == r);
      return n != 0;
   endfunction

   function automatic logic [31:0] m_rd(input int a, input bit we, input int wa, input logic [31:0] wd);
      if (a == 0) return 32'h0;
      if (BYP && we && wa == a) return wd;
      return mreg[a];
   endfunction

   task automatic m_clear();
      for (int r = 0; r < NR; r++) begin
         mcnt[r] = 0;
         mreg[r] = '0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      idle();
      @(negedge clk);
      reset = 1'b1;
      m_clear();
   endtask

   initial begin
      logic [31:0] bbv;
      reset = 1'b0;
      idle();
      m_clear();

      vt[0]  = mk(0, 0, 0, 2'b00, 5, 31, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      vt[1]  = mk(1, 1, 3, 2'b00, 5, 31, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      vt[2]  = mk(1, 0, 0, 2'b01, 3, 31, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h0, 32'h8);
      vt[3]  = mk(1, 0, 0, 2'b01, 3, 31, 1, 3, 32'hDEADBEEF, 0, 0,
                  !BYP, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'h8);
      vt[4]  = mk(1, 0, 0, 2'b11, 3, 3, 0, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
      vt[5]  = mk(1, 1, 7, 2'b00, 7, 31, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      vt[6]  = mk(1, 1, 7, 2'b00, 7, 31, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h80);
      vt[7]  = mk(1, 1, 7, 2'b00, 7, 31, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h80);
      vt[8]  = mk(1, 1, 7, 2'b00, 7, 31, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h0, 32'h80);
      vt[9]  = mk(1, 1, 9, 2'b00, 9, 31, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h80);
      vt[10] = mk(1, 1, 9, 2'b00, 9, 31, 1, 9, 32'h99, 1, 9,
                  0, BYP ? 32'h99 : 32'h0, 32'h0, 32'h280);
      vt[11] = mk(1, 0, 0, 2'b01, 9, 7, 0, 0, 32'h0, 0, 0, 0, 32'h99, 32'h0, 32'h80);
      vt[12] = mk(1, 1, 0, 2'b01, 0, 31, 1, 0, 32'h1234, 0, 0, 0, 32'h0, 32'h0, 32'h80);
      vt[13] = mk(1, 1, 0, 2'b11, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h80);
      vt[14] = mk(0, 0, 0, 2'b00, 7, 31, 1, 7, 32'h77, 1, 7,
                  0, BYP ? 32'h77 : 32'h0, 32'h0, 32'h80);
      vt[15] = mk(1, 0, 0, 2'b10, 5, 7, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h77, 32'h80);
      vt[16] = mk(1, 0, 0, 2'b10, 5, 7, 0, 0, 32'h0, 1, 7, !BYP, 32'h0, 32'h77, 32'h80);
      vt[17] = mk(1, 0, 0, 2'b10, 5, 7, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h77, 32'h0);

      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Directed vectors, one per cycle, sampled mid-low-phase.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vt[i].xs));
         check($sformatf("vec%0d_rd0", i), 64'(rd_data[31:0]), 64'(vt[i].xd0));
         check($sformatf("vec%0d_rd1", i), 64'(rd_data[63:32]), 64'(vt[i].xd1));
         check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].xbusy));
      end

      // Randomized traffic against the model; decrements only target registers with writers outstanding.
      pulse_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit          iv, iw, we, kv, st;
         int          dest, a0, a1, wa, kd, n;
         logic [1:0]  re;
         logic [31:0] wd;
         int          cand [$];
         int          left [NR];
         @(negedge clk);
         iv   = ($urandom_range(0, 9) < 7);
         iw   = 1'($urandom_range(0, 1));
         dest = int'($urandom_range(0, 7));
         re   = 2'($urandom_range(0, 3));
         a0   = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
         a1   = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
         wd   = $urandom;
         cand.delete();
         for (int r = 1; r < 8; r++) if (mcnt[r] > 0) cand.push_back(r);
         we = 0; wa = 0;
         if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            we = 1; wa = cand[$urandom_range(0, cand.size() - 1)];
         end else if ($urandom_range(0, 4) == 0) begin
            we = 1; wa = 0;
         end
         for (int r = 0; r < NR; r++) left[r] = mcnt[r] - int'(we && wa == r);
         cand.delete();
         for (int r = 1; r < 8; r++) if (left[r] > 0) cand.push_back(r);
         kv = 0; kd = 0;
         if (cand.size() > 0 && $urandom_range(0, 9) < 3) begin
            kv = 1; kd = cand[$urandom_range(0, cand.size() - 1)];
         end
         drive(mk(iv, iw, dest, re, a0, a1, we, wa, wd, kv, kd, 0, 32'h0, 32'h0, 32'h0));
         st = iv && ((re[0] && a0 != 0 && m_haz(a0, we, wa, kv, kd)) ||
                     (re[1] && a1 != 0 && m_haz(a1, we, wa, kv, kd)) ||
                     (iw && dest != 0 && mcnt[dest] == CMAX));
         bbv = '0;
         for (int r = 1; r < NR; r++) bbv[r] = (mcnt[r] != 0);
         #1;
         check($sformatf("rnd%0d_stall", cyc), 64'(stall), 64'(st));
         check($sformatf("rnd%0d_rd0", cyc), 64'(rd_data[31:0]), 64'(m_rd(a0, we, wa, wd)));
         check($sformatf("rnd%0d_rd1", cyc), 64'(rd_data[63:32]), 64'(m_rd(a1, we, wa, wd)));
         check($sformatf("rnd%0d_busy", cyc), 64'(busy), 64'(bbv));
         if (we && wa != 0) mreg[wa] = wd;
         for (int r = 1; r < NR; r++) begin
            n = mcnt[r] + int'(iv && !st && iw && dest == r) - int'(we && wa == r) - int'(kv && kd == r);
            mcnt[r] = (n < 0) ? 0 : ((n > CMAX) ? CMAX : n);
         end
      end

      // Asynchronous reset while a hazard on r4 is pending.
      pulse_reset();
      @(negedge clk);
      drive(mk(1, 1, 4, 2'b00, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
      @(negedge clk);
      drive(mk(0, 0, 0, 2'b00, 0, 0, 1, 4, 32'hABCD, 0, 0, 0, 32'h0, 32'h0, 32'h0));
      @(negedge clk);
      drive(mk(1, 1, 4, 2'b00, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
      @(negedge clk);
      drive(mk(1, 1, 4, 2'b00, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
      @(negedge clk);
      drive(mk(1, 0, 0, 2'b01, 4, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
      #1;
      check("rst_pre_stall", 64'(stall), 64'd1);
      check("rst_pre_busy", 64'(busy), 64'h10);
      check("rst_pre_rd0", 64'(rd_data[31:0]), 64'hABCD);
      reset = 1'b0;
      #1;
      check("rst_async_stall", 64'(stall), 64'd0);
      check("rst_async_busy", 64'(busy), 64'd0);
      check("rst_async_rd0", 64'(rd_data[31:0]), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_after_stall", 64'(stall), 64'd0);
      check("rst_after_busy", 64'(busy), 64'd0);
      @(negedge clk);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
